// File: rtl/text_console_pkg.sv
// Shared types, control codes and lane packing for the text-mode VRAM writer.
package text_console_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    CLEAR_ROW,
    CLEAR_ALL
  } state_t;

  localparam logic [7:0] CH_BS    = 8'h08;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_FF    = 8'h0C;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_SPACE = 8'h20;

  typedef struct packed {
    logic [3:0]  we;
    logic [31:0] din;
  } lane_wr_t;

  // Two characters share a 32-bit word: even column low half, odd column high half.
  function automatic lane_wr_t pack_lane(input logic [7:0] ch, input logic [7:0] attr,
                                         input logic odd);
    lane_wr_t w;
    w.we  = odd ? 4'b1100 : 4'b0011;
    w.din = odd ? {ch, attr, 16'h0000} : {16'h0000, ch, attr};
    return w;
  endfunction

  function automatic logic is_printable(input logic [7:0] ch);
    return (ch[6:0] >= 7'h20) && (ch[6:0] <= 7'h7E);
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Byte-stream console writer: tracks a cursor and writes glyph/attribute pairs,
// row clears and full-screen clears into text-mode VRAM over BRAM port A.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int         COLS           = 80,
  parameter int         ROWS           = 30,
  parameter int         ADDR_W         = 11,
  parameter logic [7:0] CLEAR_ATTR     = 8'h00,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic [7:0]        in_attr,
  output logic              bram_en,
  output logic [3:0]        bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [31:0]       bram_din,
  output logic [6:0]        cursor_col,
  output logic [4:0]        cursor_row,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(COLS / 2);
  localparam logic [ADDR_W-1:0] HALF_M1  = ADDR_W'(COLS / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_ALL = ADDR_W'((COLS / 2) * ROWS - 1);
  localparam logic [6:0]        LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);
  localparam logic [31:0]       CLEAR_WORD = {CH_SPACE, CLEAR_ATTR, CH_SPACE, CLEAR_ATTR};

  state_t            state_q;
  logic [6:0]        col_q;
  logic [4:0]        row_q;
  logic [7:0]        ch_q;
  logic [7:0]        attr_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              wr_odd_q;
  logic              adv_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] clr_last_q;

  logic [4:0] row_next;
  logic [6:0] col_dec;
  lane_wr_t   lane;

  function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
    return ADDR_W'(row) * HALF_A;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [6:0] col, input logic [4:0] row);
    return row_base(row) + ADDR_W'(col[6:1]);
  endfunction

  assign row_next = (row_q == LAST_ROW) ? 5'd0 : row_q + 5'd1;
  assign col_dec  = col_q - 7'd1;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
      col_q      <= '0;
      row_q      <= '0;
      ch_q       <= '0;
      attr_q     <= '0;
      wr_addr_q  <= '0;
      wr_odd_q   <= 1'b0;
      adv_q      <= 1'b0;
      clr_addr_q <= '0;
      clr_last_q <= LAST_ALL;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            ch_q   <= in_char;
            attr_q <= in_attr;
            if (is_printable(in_char)) begin
              state_q   <= WRITE;
              wr_addr_q <= word_addr(col_q, row_q);
              wr_odd_q  <= col_q[0];
              // Last column wraps and schedules a line advance after the write.
              if (col_q == LAST_COL) begin
                col_q <= '0;
                row_q <= row_next;
                adv_q <= 1'b1;
              end else begin
                col_q <= col_q + 7'd1;
                adv_q <= 1'b0;
              end
            end else if (in_char == CH_LF) begin
              row_q      <= row_next;
              clr_addr_q <= row_base(row_next);
              clr_last_q <= row_base(row_next) + HALF_M1;
              state_q    <= CLEAR_ROW;
            end else if (in_char == CH_CR) begin
              col_q <= '0;
            end else if (in_char == CH_BS) begin
              if (col_q != 7'd0) begin
                col_q     <= col_dec;
                ch_q      <= CH_SPACE;
                wr_addr_q <= word_addr(col_dec, row_q);
                wr_odd_q  <= col_dec[0];
                adv_q     <= 1'b0;
                state_q   <= WRITE;
              end
            end else if (in_char == CH_FF) begin
              col_q      <= '0;
              row_q      <= '0;
              clr_addr_q <= '0;
              clr_last_q <= LAST_ALL;
              state_q    <= CLEAR_ALL;
            end
          end
        end
        WRITE: begin
          if (adv_q) begin
            clr_addr_q <= row_base(row_q);
            clr_last_q <= row_base(row_q) + HALF_M1;
            state_q    <= CLEAR_ROW;
          end else begin
            state_q <= IDLE;
          end
        end
        CLEAR_ROW, CLEAR_ALL: begin
          if (clr_addr_q == clr_last_q) begin
            state_q <= IDLE;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign lane = pack_lane(ch_q, attr_q, wr_odd_q);

  // Port A is decoded from registered state; Reset masks it so an aborted
  // clear or write stops on the very cycle Reset is raised.
  always_comb begin
    bram_we   = 4'h0;
    bram_din  = 32'h0;
    bram_addr = '0;
    if (!Reset) begin
      case (state_q)
        WRITE: begin
          bram_we   = lane.we;
          bram_din  = lane.din;
          bram_addr = wr_addr_q;
        end
        CLEAR_ROW, CLEAR_ALL: begin
          bram_we   = 4'hF;
          bram_din  = CLEAR_WORD;
          bram_addr = clr_addr_q;
        end
        default: ;
      endcase
    end
  end

  assign bram_en    = |bram_we;
  assign in_ready   = !Reset && (state_q == IDLE);
  assign busy       = !Reset && (state_q != IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: reset clear, lane packing, wrap,
// row clears, backspace, form feed and reset-aborted clear.
module tb_text_console_writer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic [7:0]  in_attr = 8'h00;
  logic        in_ready;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [10:0] bram_addr;
  logic [31:0] bram_din;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  text_console_writer #(
    .COLS(80), .ROWS(30), .ADDR_W(11), .CLEAR_ATTR(8'h00), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .in_attr(in_attr), .bram_en(bram_en), .bram_we(bram_we),
    .bram_addr(bram_addr), .bram_din(bram_din), .cursor_col(cursor_col),
    .cursor_row(cursor_row), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c, input logic [7:0] a);
    chk("ready_before_send", 32'(in_ready), 32'd1);
    in_char  = c;
    in_attr  = a;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 3000 && !in_ready; k++) step();
    chk("idle_reached", 32'(in_ready), 32'd1);
  endtask

  initial begin
    step();
    step();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_en", 32'(bram_en), 32'd0);
    chk("rst_we", 32'(bram_we), 32'd0);
    chk("rst_addr", 32'(bram_addr), 32'd0);
    chk("rst_din", bram_din, 32'd0);
    chk("rst_col", 32'(cursor_col), 32'd0);
    chk("rst_row", 32'(cursor_row), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    Reset = 1'b0;
    #1;
    chk("init_busy", 32'(busy), 32'd1);
    chk("init_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 1200; i++) begin
      chk("init_addr", 32'(bram_addr), 32'(i));
      chk("init_we", 32'(bram_we), 32'hF);
      if (i == 0 || i == 1199) chk("init_din", bram_din, 32'h2000_2000);
      step();
    end
    chk("init_done_ready", 32'(in_ready), 32'd1);
    chk("init_done_busy", 32'(busy), 32'd0);
    chk("init_done_we", 32'(bram_we), 32'd0);
    chk("init_done_col", 32'(cursor_col), 32'd0);
    chk("init_done_row", 32'(cursor_row), 32'd0);

    send(8'h41, 8'hE2);
    chk("A_addr", 32'(bram_addr), 32'd0);
    chk("A_we", 32'(bram_we), 32'b0011);
    chk("A_din", bram_din, 32'h0000_41E2);
    chk("A_en", 32'(bram_en), 32'd1);
    step();
    send(8'h42, 8'hE2);
    chk("B_addr", 32'(bram_addr), 32'd0);
    chk("B_we", 32'(bram_we), 32'b1100);
    chk("B_din", bram_din, 32'h42E2_0000);
    step();
    chk("AB_col", 32'(cursor_col), 32'd2);

    send(8'h0D, 8'h00);
    chk("cr_ready", 32'(in_ready), 32'd1);
    chk("cr_we", 32'(bram_we), 32'd0);
    chk("cr_col", 32'(cursor_col), 32'd0);
    for (int r = 0; r < 5; r++) begin send(8'h0A, 8'h00); wait_idle(); end
    for (int c = 0; c < 79; c++) begin send(8'h2E, 8'h00); wait_idle(); end
    chk("pre_Z_col", 32'(cursor_col), 32'd79);
    chk("pre_Z_row", 32'(cursor_row), 32'd5);

    send(8'h5A, 8'h10);
    chk("Z_addr", 32'(bram_addr), 32'd239);
    chk("Z_we", 32'(bram_we), 32'b1100);
    chk("Z_din", bram_din, 32'h5A10_0000);
    step();
    for (int i = 0; i < 40; i++) begin
      chk("wrap_clr_addr", 32'(bram_addr), 32'(240 + i));
      chk("wrap_clr_we", 32'(bram_we), 32'hF);
      step();
    end
    chk("wrap_ready", 32'(in_ready), 32'd1);
    chk("wrap_col", 32'(cursor_col), 32'd0);
    chk("wrap_row", 32'(cursor_row), 32'd6);

    for (int r = 0; r < 23; r++) begin send(8'h0A, 8'h00); wait_idle(); end
    for (int c = 0; c < 3; c++) begin send(8'h2E, 8'h00); wait_idle(); end
    chk("pre_lf_col", 32'(cursor_col), 32'd3);
    chk("pre_lf_row", 32'(cursor_row), 32'd29);
    send(8'h0A, 8'h00);
    for (int i = 0; i < 40; i++) begin
      chk("lf_clr_addr", 32'(bram_addr), 32'(i));
      chk("lf_clr_ready", 32'(in_ready), 32'd0);
      step();
    end
    chk("lf_ready", 32'(in_ready), 32'd1);
    chk("lf_col", 32'(cursor_col), 32'd3);
    chk("lf_row", 32'(cursor_row), 32'd0);

    send(8'h0D, 8'h00);
    send(8'h08, 8'h5A);
    chk("bs0_we", 32'(bram_we), 32'd0);
    chk("bs0_ready", 32'(in_ready), 32'd1);
    chk("bs0_col", 32'(cursor_col), 32'd0);

    send(8'h0A, 8'h00); wait_idle();
    send(8'h0A, 8'h00); wait_idle();
    for (int c = 0; c < 5; c++) begin send(8'h2E, 8'h00); wait_idle(); end
    send(8'h08, 8'h5A);
    chk("bs_addr", 32'(bram_addr), 32'd82);
    chk("bs_we", 32'(bram_we), 32'b0011);
    chk("bs_din", bram_din, 32'h0000_205A);
    chk("bs_col", 32'(cursor_col), 32'd4);
    chk("bs_row", 32'(cursor_row), 32'd2);
    step();
    chk("bs_ready", 32'(in_ready), 32'd1);

    send(8'h0C, 8'h00);
    chk("ff_col", 32'(cursor_col), 32'd0);
    chk("ff_row", 32'(cursor_row), 32'd0);
    for (int i = 0; i < 100; i++) begin
      chk("ff_addr", 32'(bram_addr), 32'(i));
      step();
    end
    Reset = 1'b1;
    #1;
    chk("abort_we", 32'(bram_we), 32'd0);
    chk("abort_en", 32'(bram_en), 32'd0);
    chk("abort_ready", 32'(in_ready), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    step();
    Reset = 1'b0;
    #1;
    chk("restart_addr", 32'(bram_addr), 32'd0);
    chk("restart_we", 32'(bram_we), 32'hF);
    chk("restart_busy", 32'(busy), 32'd1);
    step();
    chk("restart_addr1", 32'(bram_addr), 32'd1);
    wait_idle();
    chk("final_col", 32'(cursor_col), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
